// File: rtl/trigger_capture_pkg.sv
// Shared definitions for the trigger/capture block: the acquisition state
// encoding and the sample width shared with the finder and the ADC interface.
package trigger_capture_pkg;

    // Sample width used by the ADC, the amplitude/DC-offset finder and this block.
    localparam int DATA_W_DEF = 12;

    // Acquisition states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRIME     = 3'd1,
        ST_WAIT_EDGE = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/capture_ram.sv
// Capture buffer: DEPTH x DATA_W, one write port, one registered read port.
// The memory array has no reset so it maps onto block RAM; only the read
// register is cleared. A read of the address being written on the same edge
// returns the previous contents.
module capture_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Write port: store one sample when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: registered, one cycle latency, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/trigger_capture.sv
// Trigger and capture: arms on a pulse, waits for a level crossing with
// hysteresis around a live trigger level, then stores DEPTH consecutive valid
// samples into capture_ram for readout.
// Optional build macro TRIGGER_CAPTURE_AUTO_TRIG_EN: after TIMEOUT valid
// samples without a trigger, a capture is forced and auto_trig is raised.
// Handshake: a sample is consumed only on a cycle with sample_valid=1; with
// sample_valid=0 nothing moves. arm is a one-cycle pulse honoured only in
// IDLE or DONE.
module trigger_capture
    import trigger_capture_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = 8,
    parameter int HYST    = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic              arm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              auto_trig,
    output state_e            state_dbg
);

    localparam logic [DATA_W:0] HYST_X = (DATA_W+1)'(HYST);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              done_q, done_d;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              timeout_hit;

    // Thresholds are worked out one bit wider so under/overflow is visible.
    logic [DATA_W:0]   lo_x, hi_x;
    logic [DATA_W-1:0] lo_th, hi_th;
    logic              primed, edge_hit;

    assign lo_x  = {1'b0, trig_level} - HYST_X;
    assign hi_x  = {1'b0, trig_level} + HYST_X;
    assign lo_th = lo_x[DATA_W] ? '0 : lo_x[DATA_W-1:0];
    assign hi_th = hi_x[DATA_W] ? '1 : hi_x[DATA_W-1:0];

    // Priming moves the signal to the far side of the band; the edge is the
    // crossing of the near side in the selected direction.
    assign primed   = trig_rising ? (sample_in <  lo_th) : (sample_in >  hi_th);
    assign edge_hit = trig_rising ? (sample_in >= hi_th) : (sample_in <= lo_th);

`ifdef TRIGGER_CAPTURE_AUTO_TRIG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             auto_q, auto_d;

    assign timeout_hit = (to_cnt_q == CNT_W'(TIMEOUT - 1));
    assign auto_trig   = auto_q;

    // Timeout counter and auto-trigger flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            auto_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            auto_q   <= auto_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign auto_trig   = 1'b0;
`endif

    // State, write pointer and done flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            done_q   <= done_d;
        end
    end

    // Next-state, buffer write and counter updates.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        done_d   = done_q;
        we       = 1'b0;
        waddr    = wr_ptr_q;
`ifdef TRIGGER_CAPTURE_AUTO_TRIG_EN
        to_cnt_d = to_cnt_q;
        auto_d   = auto_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d = ST_PRIME;
                    done_d  = 1'b0;
`ifdef TRIGGER_CAPTURE_AUTO_TRIG_EN
                    to_cnt_d = '0;
                    auto_d   = 1'b0;
`endif
                end
            end
            ST_PRIME, ST_WAIT_EDGE: begin
                if (sample_valid) begin
`ifdef TRIGGER_CAPTURE_AUTO_TRIG_EN
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                    if ((state_q == ST_WAIT_EDGE && edge_hit) || timeout_hit) begin
                        // Triggering sample is the first entry of the capture.
                        state_d  = ST_CAPTURE;
                        we       = 1'b1;
                        waddr    = '0;
                        wr_ptr_d = ADDR_W'(1);
`ifdef TRIGGER_CAPTURE_AUTO_TRIG_EN
                        auto_d = !(state_q == ST_WAIT_EDGE && edge_hit);
`endif
                    end else if (state_q == ST_PRIME && primed) begin
                        state_d = ST_WAIT_EDGE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (sample_valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == '1) begin
                        // Last address written; pointer wraps back to 0.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    capture_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we && !rst),
        .wr_addr_i(waddr),
        .wr_data_i(sample_in),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data)
    );

    assign busy      = (state_q == ST_PRIME) || (state_q == ST_WAIT_EDGE) ||
                       (state_q == ST_CAPTURE);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule
